// File: rtl/branch_resolution_unit.sv
// ---------------------------------------------------------------------------
// branch_resolution_unit
//
// Purpose:
//   Tracks in-flight branch predictions in an in-order FIFO and retires them
//   against execute-side resolutions. Each resolution produces a one-cycle
//   training pulse for the global/local predictors and, when the two
//   component predictors disagreed, a training pulse for the tournament
//   chooser. A mispredicted branch starts a one-cycle FLUSH. During FLUSH
//   the pipeline is squashed, fetch is redirected and all younger
//   predictions are discarded.
//
// Parameters:
//   DEPTH  number of in-flight predictions (power of 2, >= 2)
//   PC_W   width of PCs and branch targets
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   pred_valid/pred_ready    fetch-side prediction record handshake
//   pred_pc, pred_taken,     predicted branch PC, final direction, target,
//   pred_target, glob_pred,  and the votes of the global and local
//   local_pred               component predictors
//   res_valid, res_br_en,    resolution of the oldest in-flight branch
//   res_target
//   upd_ld, upd_pc,          predictor training pulse (one cycle after
//   upd_br_en                the resolution)
//   chooser_ld, chooser_dir  chooser training pulse (1 = favour global)
//   flush, redirect_pc       pipeline squash and refetch address
//   resolved_cnt,            performance counters
//   mispred_cnt
//
// Configuration:
//   BRU_PERF_CNT_EN  when defined, resolved_cnt / mispred_cnt count
//                    resolutions and mispredictions (wrapping). When it is
//                    undefined, both outputs are tied to zero and no
//                    counter flops exist.
// ---------------------------------------------------------------------------
module branch_resolution_unit #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_valid,
    input  logic [PC_W-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    input  logic            glob_pred,
    input  logic            local_pred,
    output logic            pred_ready,
    input  logic            res_valid,
    input  logic            res_br_en,
    input  logic [PC_W-1:0] res_target,
    output logic            upd_ld,
    output logic [PC_W-1:0] upd_pc,
    output logic            upd_br_en,
    output logic            chooser_ld,
    output logic            chooser_dir,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     resolved_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    // Prediction record storage, one field per array
    logic [PC_W-1:0] fifo_pc     [DEPTH];
    logic            fifo_taken  [DEPTH];
    logic [PC_W-1:0] fifo_target [DEPTH];
    logic            fifo_glob   [DEPTH];
    logic            fifo_local  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic            head_taken;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] head_target;
    logic            head_glob;
    logic            head_local;

    logic push;
    logic resolve;
    logic mispredict;
    logic flush_start;

    // Fields of the oldest in-flight prediction
    assign head_pc     = fifo_pc[rd_ptr];
    assign head_taken  = fifo_taken[rd_ptr];
    assign head_target = fifo_target[rd_ptr];
    assign head_glob   = fifo_glob[rd_ptr];
    assign head_local  = fifo_local[rd_ptr];

    // A resolution only counts when a branch is actually in flight. It is
    // ignored during the squash cycle.
    assign resolve    = res_valid && (count != '0) && (state == RUN);
    assign push       = pred_valid && pred_ready;

    // A not-taken branch has no meaningful target, so the target is
    // compared only when the branch was actually taken.
    assign mispredict = (res_br_en != head_taken) ||
                        (res_br_en && (res_target != head_target));
    assign flush_start = resolve && mispredict;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state and state-derived outputs. FLUSH always lasts exactly one
    // cycle.
    always_comb begin
        next_state = state;
        flush      = 1'b0;
        pred_ready = 1'b0;
        case (state)
            RUN: begin
                pred_ready = (count != FULL_COUNT);
                if (flush_start) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                flush      = 1'b1;
                next_state = RUN;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Record storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]     <= pred_pc;
            fifo_taken[wr_ptr]  <= pred_taken;
            fifo_target[wr_ptr] <= pred_target;
            fifo_glob[wr_ptr]   <= glob_pred;
            fifo_local[wr_ptr]  <= local_pred;
        end
    end

    // Pointers and occupancy. A mispredict discards every younger record.
    // This includes a push offered in the resolving cycle, so the FIFO is
    // already empty when FLUSH is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (resolve) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, resolve})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Training pulses, registered one cycle after the resolution. The
    // chooser is only trained when the two component predictors disagreed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_ld      <= 1'b0;
            upd_pc      <= '0;
            upd_br_en   <= 1'b0;
            chooser_ld  <= 1'b0;
            chooser_dir <= 1'b0;
        end else begin
            upd_ld     <= resolve;
            chooser_ld <= resolve && (head_glob != head_local);
            if (resolve) begin
                upd_pc      <= head_pc;
                upd_br_en   <= res_br_en;
                chooser_dir <= (head_glob == res_br_en);
            end
        end
    end

    // Refetch address, captured at the resolving edge and held afterwards.
    // The fall-through address wraps modulo 2^PC_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_pc <= '0;
        end else if (flush_start) begin
            redirect_pc <= res_br_en ? res_target : head_pc + PC_W'(4);
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Free-running performance counters that wrap naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resolved_cnt <= '0;
            mispred_cnt  <= '0;
        end else if (resolve) begin
            resolved_cnt <= resolved_cnt + 32'd1;
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end
`else
    assign resolved_cnt = '0;
    assign mispred_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolution_unit
//
// Purpose:
//   Self-checking bench for branch_resolution_unit (DEPTH=4, PC_W=32).
//   A queue-based reference model predicts every output cycle by cycle, and
//   a compare process checks the DUT on each falling clock edge. Directed
//   scenarios also pin key values with hand-computed literals.
//   Honours BRU_PERF_CNT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_branch_resolution_unit;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic            clk;
    logic            rst;
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            glob_pred;
    logic            local_pred;
    logic            pred_ready;
    logic            res_valid;
    logic            res_br_en;
    logic [PC_W-1:0] res_target;
    logic            upd_ld;
    logic [PC_W-1:0] upd_pc;
    logic            upd_br_en;
    logic            chooser_ld;
    logic            chooser_dir;
    logic            flush;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     resolved_cnt;
    logic [31:0]     mispred_cnt;

    int checks = 0;
    int passes = 0;

    branch_resolution_unit #(
        .DEPTH(DEPTH),
        .PC_W (PC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pred_valid  (pred_valid),
        .pred_pc     (pred_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .glob_pred   (glob_pred),
        .local_pred  (local_pred),
        .pred_ready  (pred_ready),
        .res_valid   (res_valid),
        .res_br_en   (res_br_en),
        .res_target  (res_target),
        .upd_ld      (upd_ld),
        .upd_pc      (upd_pc),
        .upd_br_en   (upd_br_en),
        .chooser_ld  (chooser_ld),
        .chooser_dir (chooser_dir),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .resolved_cnt(resolved_cnt),
        .mispred_cnt (mispred_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------------
    // Reference model: a queue of outstanding predictions plus the expected
    // registered outputs
    // ---------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        g;
        logic        l;
    } rec_t;

    rec_t        mq[$];
    bit          m_flush;
    logic        m_upd_ld;
    logic [31:0] m_upd_pc;
    logic        m_upd_br_en;
    logic        m_ch_ld;
    logic        m_ch_dir;
    logic [31:0] m_redirect;
    int unsigned m_resolved;
    int unsigned m_mispred;

    always @(posedge clk or negedge rst) begin
        bit   can_push;
        bit   do_res;
        bit   mis;
        rec_t h;
        rec_t n;
        if (!rst) begin
            mq.delete();
            m_flush     = 1'b0;
            m_upd_ld    = 1'b0;
            m_upd_pc    = '0;
            m_upd_br_en = 1'b0;
            m_ch_ld     = 1'b0;
            m_ch_dir    = 1'b0;
            m_redirect  = '0;
            m_resolved  = 0;
            m_mispred   = 0;
        end else begin
            can_push = pred_valid && (mq.size() < DEPTH) && !m_flush;
            do_res   = res_valid && (mq.size() > 0) && !m_flush;
            mis      = 1'b0;
            m_upd_ld = do_res;
            m_ch_ld  = 1'b0;
            if (do_res) begin
                h = mq.pop_front();
                mis = (res_br_en != h.taken) || (res_br_en && res_target != h.target);
                m_upd_pc    = h.pc;
                m_upd_br_en = res_br_en;
                m_ch_ld     = (h.g != h.l);
                m_ch_dir    = (h.g == res_br_en);
                m_resolved++;
                if (mis) begin
                    m_mispred++;
                    m_redirect = res_br_en ? res_target : h.pc + 32'd4;
                end
            end
            if (mis) begin
                mq.delete();
            end else if (can_push) begin
                n.pc     = pred_pc;
                n.taken  = pred_taken;
                n.target = pred_target;
                n.g      = glob_pred;
                n.l      = local_pred;
                mq.push_back(n);
            end
            m_flush = mis;
        end
    end

    function automatic logic [31:0] expResolved();
`ifdef BRU_PERF_CNT_EN
        return m_resolved;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] expMispred();
`ifdef BRU_PERF_CNT_EN
        return m_mispred;
`else
        return 32'd0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Compare process: checks the DUT against the model on every falling edge
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("cmp_pred_ready", {31'd0, pred_ready},
                        {31'd0, (mq.size() < DEPTH) && !m_flush});
            checkOutput("cmp_flush", {31'd0, flush}, {31'd0, m_flush});
            checkOutput("cmp_redirect_pc", redirect_pc, m_redirect);
            checkOutput("cmp_upd_ld", {31'd0, upd_ld}, {31'd0, m_upd_ld});
            checkOutput("cmp_chooser_ld", {31'd0, chooser_ld}, {31'd0, m_ch_ld});
            checkOutput("cmp_resolved_cnt", resolved_cnt, expResolved());
            checkOutput("cmp_mispred_cnt", mispred_cnt, expMispred());
            if (m_upd_ld) begin
                checkOutput("cmp_upd_pc", upd_pc, m_upd_pc);
                checkOutput("cmp_upd_br_en", {31'd0, upd_br_en}, {31'd0, m_upd_br_en});
            end
            if (m_ch_ld) begin
                checkOutput("cmp_chooser_dir", {31'd0, chooser_dir}, {31'd0, m_ch_dir});
            end
        end else begin
            checkOutput("rst_flush", {31'd0, flush}, 32'd0);
            checkOutput("rst_upd_ld", {31'd0, upd_ld}, 32'd0);
            checkOutput("rst_upd_pc", upd_pc, 32'd0);
            checkOutput("rst_upd_br_en", {31'd0, upd_br_en}, 32'd0);
            checkOutput("rst_chooser_ld", {31'd0, chooser_ld}, 32'd0);
            checkOutput("rst_chooser_dir", {31'd0, chooser_dir}, 32'd0);
            checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
            checkOutput("rst_resolved_cnt", resolved_cnt, 32'd0);
            checkOutput("rst_mispred_cnt", mispred_cnt, 32'd0);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after a rising edge.
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        pred_valid  = 1'b0;
        pred_pc     = '0;
        pred_taken  = 1'b0;
        pred_target = '0;
        glob_pred   = 1'b0;
        local_pred  = 1'b0;
        res_valid   = 1'b0;
        res_br_en   = 1'b0;
        res_target  = '0;
    endtask

    task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic tk,
                                 input logic [31:0] tgt, input logic g, input logic l,
                                 input logic rv, input logic be, input logic [31:0] rt);
        pred_valid  = pv;
        pred_pc     = pc;
        pred_taken  = tk;
        pred_target = tgt;
        glob_pred   = g;
        local_pred  = l;
        res_valid   = rv;
        res_br_en   = be;
        res_target  = rt;
        step();
        idleInputs();
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic g, input logic l);
        applyStimulus(1'b1, pc, tk, tgt, g, l, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic resolve(input logic be, input logic [31:0] rt);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, be, rt);
    endtask

    initial begin
        idleInputs();
        rst = 1'b0;
        #2;
        checkOutput("reset_flush", {31'd0, flush}, 32'd0);
        checkOutput("reset_upd_ld", {31'd0, upd_ld}, 32'd0);
        checkOutput("reset_redirect", redirect_pc, 32'd0);
        step();
        step();
        rst = 1'b1;

        // Correctly predicted taken branch
        push(32'h100, 1'b1, 32'h200, 1'b1, 1'b1);
        resolve(1'b1, 32'h200);
        checkOutput("hit_upd_ld", {31'd0, upd_ld}, 32'd1);
        checkOutput("hit_upd_pc", upd_pc, 32'h100);
        checkOutput("hit_upd_br_en", {31'd0, upd_br_en}, 32'd1);
        checkOutput("hit_flush", {31'd0, flush}, 32'd0);
        step();
        checkOutput("hit_upd_ld_drop", {31'd0, upd_ld}, 32'd0);

        // Predicted not-taken, actually taken
        push(32'h100, 1'b0, 32'h300, 1'b0, 1'b0);
        resolve(1'b1, 32'h180);
        checkOutput("mis_flush", {31'd0, flush}, 32'd1);
        checkOutput("mis_redirect", redirect_pc, 32'h180);
        checkOutput("mis_pred_ready", {31'd0, pred_ready}, 32'd0);
        step();
        checkOutput("mis_flush_end", {31'd0, flush}, 32'd0);
        checkOutput("mis_ready_back", {31'd0, pred_ready}, 32'd1);
        resolve(1'b0, 32'd0);
        checkOutput("empty_after_flush", {31'd0, upd_ld}, 32'd0);

        // Predicted taken, actually not taken; components disagreed
        push(32'h40, 1'b1, 32'h80, 1'b0, 1'b1);
        resolve(1'b0, 32'd0);
        checkOutput("nt_redirect", redirect_pc, 32'h44);
        checkOutput("nt_chooser_ld", {31'd0, chooser_ld}, 32'd1);
        checkOutput("nt_chooser_dir", {31'd0, chooser_dir}, 32'd1);
        step();

        // Fill to capacity, offer a push while full, then drain
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h1000 + 32'(i * 4), 1'b0, 32'd0, 1'b0, 1'b0);
        end
        checkOutput("full_ready", {31'd0, pred_ready}, 32'd0);
        push(32'h2000, 1'b0, 32'd0, 1'b0, 1'b0);
        resolve(1'b0, 32'd0);
        checkOutput("full_pop_ready", {31'd0, pred_ready}, 32'd1);
        checkOutput("full_pop_pc", upd_pc, 32'h1000);
        for (int i = 1; i < DEPTH; i++) begin
            resolve(1'b0, 32'd0);
        end
        checkOutput("drain_last_pc", upd_pc, 32'h100C);
        resolve(1'b0, 32'd0);
        checkOutput("resolve_empty", {31'd0, upd_ld}, 32'd0);

        // Simultaneous push and correct resolution
        push(32'h3000, 1'b1, 32'h3100, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h3004, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3100);
        checkOutput("pp_chooser_dir", {31'd0, chooser_dir}, 32'd1);
        resolve(1'b0, 32'd0);
        checkOutput("pp_second_pc", upd_pc, 32'h3004);

        // A push offered in a mispredicting cycle is dropped
        push(32'h5000, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5004, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500);
        checkOutput("drop_redirect", redirect_pc, 32'h500);
        step();
        resolve(1'b0, 32'd0);
        checkOutput("drop_no_upd", {31'd0, upd_ld}, 32'd0);

        // Fall-through address wraps at 2^32
        push(32'hFFFF_FFFC, 1'b1, 32'h8, 1'b0, 1'b0);
        resolve(1'b0, 32'd0);
        checkOutput("wrap_redirect", redirect_pc, 32'h0);
        step();

        // Reset asserted during FLUSH
        push(32'h10, 1'b0, 32'd0, 1'b0, 1'b0);
        resolve(1'b1, 32'h700);
        rst = 1'b0;
        #1;
        checkOutput("rstflush_flush", {31'd0, flush}, 32'd0);
        checkOutput("rstflush_upd_ld", {31'd0, upd_ld}, 32'd0);
        checkOutput("rstflush_redirect", redirect_pc, 32'd0);
        step();
        rst = 1'b1;
        step();
        step();
        checkOutput("rstflush_after", {31'd0, flush}, 32'd0);

        // Three resolutions, one mispredicted
        push(32'h20, 1'b1, 32'h60, 1'b1, 1'b1);
        resolve(1'b1, 32'h60);
        push(32'h24, 1'b0, 32'd0, 1'b0, 1'b0);
        resolve(1'b0, 32'd0);
        push(32'h28, 1'b0, 32'd0, 1'b1, 1'b0);
        resolve(1'b1, 32'h90);
        step();
`ifdef BRU_PERF_CNT_EN
        checkOutput("perf_resolved", resolved_cnt, 32'd3);
        checkOutput("perf_mispred", mispred_cnt, 32'd1);
`else
        checkOutput("perf_resolved", resolved_cnt, 32'd0);
        checkOutput("perf_mispred", mispred_cnt, 32'd0);
`endif
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of in-flight predictions (power of 2, >=2).
REQ-002 SHALL have parameter PC_W, default 32, meaning PC and target width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports pred_valid in 1, pred_pc in PC_W, pred_taken in 1, pred_target in PC_W, glob_pred in 1, local_pred in 1: one fetch-side prediction record (final direction, target, both component votes).
REQ-006 SHALL have port pred_ready  out  1  record accepted this cycle when pred_valid=1.
REQ-007 SHALL have ports res_valid in 1, res_br_en in 1, res_target in PC_W: execute-side resolution of the oldest in-flight branch.
REQ-008 SHALL have ports upd_ld out 1, upd_pc out PC_W, upd_br_en out 1: training for global and local predictors.
REQ-009 SHALL have ports chooser_ld out 1, chooser_dir out 1 (1=favor global): training for the tournament chooser.
REQ-010 SHALL have ports flush out 1, redirect_pc out PC_W: pipeline squash and refetch address.
REQ-011 SHALL have ports resolved_cnt out 32, mispred_cnt out 32: performance counters.

Function
REQ-012 SHALL hold records in an in-order FIFO of DEPTH entries; push on pred_valid&&pred_ready, pop on res_valid when non-empty.
REQ-013 SHALL drive pred_ready = !full && state==RUN (combinational).
REQ-014 SHALL accept push and pop in the same cycle at full (pop frees slot; pred_ready stays 0 at full, so such a push is not offered).
REQ-015 SHALL ignore res_valid when FIFO empty: no pop, no outputs, no counter change.
REQ-016 SHALL compute mispredict = (res_br_en != head.pred_taken) || (res_br_en && res_target != head.pred_target).
REQ-017 SHALL, one cycle after a valid resolution, pulse upd_ld=1 for one cycle with upd_pc=head.pred_pc, upd_br_en=res_br_en.
REQ-018 SHALL, in the same cycle as upd_ld, pulse chooser_ld=1 only if head.glob_pred != head.local_pred, with chooser_dir = (head.glob_pred == res_br_en).
REQ-019 SHALL use FSM states RUN and FLUSH; RUN->FLUSH on valid mispredicting resolution; FLUSH->RUN unconditionally after one cycle.
REQ-020 SHALL, in FLUSH, assert flush=1 with redirect_pc = res_br_en ? res_target : head.pred_pc+4 (captured at resolution, modulo 2^PC_W), empty the FIFO, and drop any push offered in the resolving cycle.
REQ-021 SHALL hold flush=0, upd_ld=0, chooser_ld=0 in every other cycle; redirect_pc holds its last value.
REQ-022 SHALL ignore res_valid while in FLUSH.
REQ-023 SHALL wrap FIFO pointers modulo DEPTH and track occupancy with a DEPTH+1-valued count.

Reset
REQ-024 SHALL, while rst=0, clear FIFO (empty), state=RUN, upd_ld=0, upd_pc=0, upd_br_en=0, chooser_ld=0, chooser_dir=0, flush=0, redirect_pc=0, counters=0.
REQ-025 SHALL, on reset mid-FLUSH or mid-resolution, abandon the operation with no pulse after release.
REQ-026 SHALL accept a push in the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, with BRU_PERF_CNT_EN defined, increment resolved_cnt per valid resolution and mispred_cnt per mispredict, both wrapping 0xFFFFFFFF->0.
REQ-028 SHALL, without BRU_PERF_CNT_EN, tie resolved_cnt and mispred_cnt to 0 and instantiate no counter flops.

Verification
REQ-029 SHALL cover: push pc=0x100 taken=1 target=0x200, resolve br_en=1 target=0x200 -> upd_ld next cycle, upd_pc=0x100, flush=0.
REQ-030 SHALL cover: push pc=0x100 taken=0, resolve br_en=1 target=0x180 -> flush=1 one cycle later, redirect_pc=0x180, FIFO empty, pred_ready=0 that cycle.
REQ-031 SHALL cover: push pc=0x40 taken=1, resolve br_en=0 -> redirect_pc=0x44; glob_pred=0 local_pred=1 -> chooser_ld=1, chooser_dir=1.
REQ-032 SHALL cover: push 4 records (DEPTH=4) -> pred_ready=0; resolve one -> pred_ready=1 next cycle; resolve on empty -> no upd_ld.
REQ-033 SHALL cover: assert rst=0 during FLUSH -> all outputs 0 immediately, no flush after release.
REQ-034 SHALL cover: BRU_PERF_CNT_EN defined, 3 resolutions incl. 1 mispredict -> resolved_cnt=3, mispred_cnt=1; undefined -> both 0.
